// File: rtl/sort_top_v2.sv
// Memory-mapped sort accelerator: local MM x MN buffer plus an early-exit bubble-sort engine
// with direction/signedness control, host abort, saturating cycle counter and done interrupt.
module sort_top_v2 #(
    parameter int          MM   = 256,
    parameter int          MN   = 32,
    parameter int          MW   = 8,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic        Wr,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] Data,
    output logic        irq
);
    typedef enum logic [2:0] {IDLE, CHECK, RD_A, RD_B, CMP, WR_A, WR_B, DONE} state_t;

    localparam logic [MW:0] MM_V = (MW+1)'(MM);
    localparam logic [MW:0] ONE  = (MW+1)'(1);

    function automatic logic need_swap(input logic [MN-1:0] a, input logic [MN-1:0] b,
                                       input logic desc, input logic sgn);
        logic gt, lt;
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        return desc ? lt : gt;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t        state;
    logic [MN-1:0] mem [MM];
    logic [MN-1:0] rd_q, a_val, b_val, mem_wd;
    logic [MW:0]   num, last, idx, eng_idx;
    logic [2:0]    ctrl;
    logic [1:0]    code;
    logic          done_flag, swapped, rd_is_buf;
    logic [31:0]   cycles, reg_q, reg_rdata;
    logic          sel, busy, rd_acc, wr_acc, buf_sel, in_range;
    logic          start_go, abort_go, stat_rd, swap_c, end_of_pair, mem_we;
    logic [MW-1:0] host_idx, mem_addr;
    logic [9:0]    reg_word;
    logic          unused_bits;

    assign sel         = En && (Addr[31:12] == BASE[31:12]);
    assign busy        = (state != IDLE);
    assign rd_acc      = sel && !Wr;
    assign wr_acc      = sel && Wr;
    assign buf_sel     = !Addr[11];
    assign reg_word    = Addr[11:2];
    assign host_idx    = Addr[2 +: MW];
    assign in_range    = ({1'b0, host_idx} < MM_V);
    assign start_go    = wr_acc && !buf_sel && (reg_word == 10'h201) && WrData[0] && !busy;
    assign abort_go    = wr_acc && !buf_sel && (reg_word == 10'h201) && WrData[1] && busy;
    assign stat_rd     = rd_acc && !buf_sel && (reg_word == 10'h202);
    assign swap_c      = need_swap(a_val, rd_q, ctrl[0], ctrl[1]);
    assign end_of_pair = ((state == CMP) && !swap_c) || (state == WR_B);
    assign unused_bits = ^{Addr, WrData};

    // The engine owns the single buffer port whenever the FSM is not idle.
    assign eng_idx  = ((state == RD_B) || (state == WR_B)) ? idx + ONE : idx;
    assign mem_addr = busy ? eng_idx[MW-1:0] : host_idx;
    assign mem_we   = busy ? ((state == WR_A) || ((state == WR_B) && !abort_go))
                           : (wr_acc && buf_sel && in_range);
    assign mem_wd   = busy ? ((state == WR_A) ? b_val : a_val) : WrData[MN-1:0];

    assign Data = rd_is_buf ? 32'(rd_q) : reg_q;
    assign irq  = done_flag & ctrl[2];

    always_comb begin
        reg_rdata = 32'd0;
        case (reg_word)
            10'h200: reg_rdata = 32'(num);
            10'h202: reg_rdata = {28'd0, done_flag, code, busy};
            10'h203: reg_rdata = {29'd0, ctrl};
            10'h204: reg_rdata = cycles;
            default: reg_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
        rd_q <= mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (state == RD_B) a_val <= rd_q;
        if (state == CMP)  b_val <= rd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            num       <= '0;
            last      <= '0;
            idx       <= '0;
            swapped   <= 1'b0;
            ctrl      <= '0;
            code      <= '0;
            done_flag <= 1'b0;
            cycles    <= '0;
            rd_is_buf <= 1'b0;
            reg_q     <= '0;
        end else begin
            rd_is_buf <= rd_acc && buf_sel && in_range && !busy;
            reg_q     <= (rd_acc && !buf_sel) ? reg_rdata : 32'd0;
            if (stat_rd) done_flag <= 1'b0;
            if (start_go)  cycles <= '0;
            else if (busy) cycles <= sat_inc(cycles);
            if (wr_acc && !buf_sel && !busy) begin
                if (reg_word == 10'h200) num  <= WrData[MW:0];
                if (reg_word == 10'h203) ctrl <= WrData[2:0];
            end
            if (abort_go) begin
                state <= IDLE;
                code  <= 2'd2;
            end else begin
                case (state)
                    IDLE: if (start_go) begin
                        state <= CHECK;
                        code  <= 2'd0;
                        last  <= num - ONE;
                    end
                    CHECK: begin
                        if ((num == '0) || (num > MM_V)) begin
                            state <= IDLE;
                            code  <= 2'd1;
                        end else if (num == ONE) begin
                            state <= DONE;
                        end else begin
                            state   <= RD_A;
                            idx     <= '0;
                            swapped <= 1'b0;
                        end
                    end
                    RD_A: state <= RD_B;
                    RD_B: state <= CMP;
                    CMP: if (swap_c) begin
                        state   <= WR_A;
                        swapped <= 1'b1;
                    end
                    WR_A: state <= WR_B;
                    WR_B: ;
                    DONE: begin
                        state     <= IDLE;
                        done_flag <= 1'b1;
                        code      <= 2'd0;
                    end
                    default: state <= IDLE;
                endcase
                // Next pair in this pass, early exit, or a shorter pass.
                if (end_of_pair) begin
                    if (idx + ONE < last) begin
                        idx   <= idx + ONE;
                        state <= RD_A;
                    end else if (!swapped || (last == ONE)) begin
                        state <= DONE;
                    end else begin
                        last    <= last - ONE;
                        idx     <= '0;
                        swapped <= 1'b0;
                        state   <= RD_A;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sort_top_v2.sv
// Bench for sort_top_v2: bus-level stimulus, array-based sort model, per-cycle Data/irq compare.
module tb_sort_top_v2;
    localparam int          MM   = 256;
    localparam int          MN   = 32;
    localparam int          MW   = 8;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        En = 1'b0, Wr = 1'b0;
    logic [31:0] Addr = '0, WrData = '0;
    logic [31:0] Data;
    logic        irq;

    sort_top_v2 #(.MM(MM), .MN(MN), .MW(MW), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .En(En), .Wr(Wr), .Addr(Addr),
        .WrData(WrData), .Data(Data), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference state of the block as seen by the host.
    logic [31:0] m_mem [MM];
    int          m_num = 0;
    logic [2:0]  m_ctrl = '0;
    logic        m_done = 1'b0;
    logic [1:0]  m_code = '0;
    logic [31:0] m_cycles = '0;

    // Expectations for the edge that samples the currently driven access.
    logic [31:0] drv_exp = '0, last_exp = '0;
    logic        drv_known = 1'b0, last_known = 1'b0;
    logic        drv_irq = 1'b0, last_irq = 1'b0;
    logic        drv_irq_known = 1'b0, last_irq_known = 1'b0;
    string       drv_tag = "none", last_tag = "none";

    always @(negedge clk) begin
        if (last_known) begin
            total++;
            if (Data !== last_exp) begin
                bad++;
                $display("FAIL data[%s]: got %h want %h", last_tag, Data, last_exp);
            end
        end
        if (last_irq_known) begin
            total++;
            if (irq !== last_irq) begin
                bad++;
                $display("FAIL irq[%s]: got %b want %b", last_tag, irq, last_irq);
            end
        end
        last_exp = drv_exp; last_known = drv_known;
        last_irq = drv_irq; last_irq_known = drv_irq_known; last_tag = drv_tag;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic bus(input logic en, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input string tag);
        @(posedge clk); #1;
        En = en; Wr = wr; Addr = addr; WrData = wd;
        drv_exp = exp; drv_known = 1'b1; drv_tag = tag;
        drv_irq = m_done & m_ctrl[2]; drv_irq_known = 1'b1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input string tag);
        bus(1'b1, 1'b1, BASE | off, d, 32'd0, tag);
    endtask
    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
        bus(1'b1, 1'b0, BASE | off, 32'd0, exp, tag);
    endtask
    task automatic idle();
        bus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, "idle");
    endtask

    task automatic buf_wr(input int i, input logic [31:0] d);
        m_mem[i] = d;
        wr(32'(i * 4), d, "buf wr");
    endtask
    task automatic load4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        buf_wr(0, a); buf_wr(1, b); buf_wr(2, c); buf_wr(3, d);
    endtask
    task automatic check_buf(input int n);
        for (int i = 0; i < n; i++) rd(32'(i * 4), m_mem[i], "buf rd");
    endtask
    task automatic set_num(input int n);
        m_num = n;
        wr(32'h800, 32'(n), "num wr");
    endtask
    task automatic set_ctrl(input logic [2:0] c);
        m_ctrl = c;
        wr(32'h80C, 32'(c), "ctrl wr");
    endtask
    task automatic rd_status();
        logic [31:0] st;
        st = {28'd0, m_done, m_code, 1'b0};
        m_done = 1'b0;
        rd(32'h808, st, "status");
    endtask

    function automatic logic out_of_order(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        logic gt, lt;
        gt = c[1] ? ($signed(a) > $signed(b)) : (a > b);
        lt = c[1] ? ($signed(a) < $signed(b)) : (a < b);
        return c[0] ? lt : gt;
    endfunction

    // Sorts m_mem[0..n-1] in place; returns busy cycles (CHECK + pairs at 3 or 5 + DONE).
    function automatic int model_sort(input int n, input logic [2:0] c);
        int cyc, last;
        logic sw;
        logic [31:0] t;
        if (n == 0 || n > MM) return 1;
        cyc = 2;
        last = n - 1;
        while (last >= 1) begin
            sw = 1'b0;
            for (int i = 0; i < last; i++) begin
                cyc += 3;
                if (out_of_order(m_mem[i], m_mem[i+1], c)) begin
                    t = m_mem[i]; m_mem[i] = m_mem[i+1]; m_mem[i+1] = t;
                    cyc += 2;
                    sw = 1'b1;
                end
            end
            if (!sw) break;
            last--;
        end
        return cyc;
    endfunction

    // Start, poll busy once, wait exactly the predicted time, then STATUS and CYCLES.
    task automatic run_sort(output int cyc);
        logic ok;
        logic [31:0] st;
        ok = (m_num != 0) && (m_num <= MM);
        cyc = model_sort(m_num, m_ctrl);
        m_code = 2'd0;
        wr(32'h804, 32'd1, "start");
        st = {28'd0, m_done, 2'b00, 1'b1};
        m_done = 1'b0;
        rd(32'h808, st, "status busy");
        if (!ok) m_code = 2'd1;
        for (int k = 2; k <= cyc; k++) begin
            if (k == cyc) begin m_done = 1'b1; m_code = 2'd0; end
            idle();
        end
        m_cycles = 32'(cyc);
        rd_status();
        rd(32'h810, m_cycles, "cycles");
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; En = 1'b0; Wr = 1'b0;
        drv_exp = '0; drv_known = 1'b1; drv_irq = 1'b0; drv_irq_known = 1'b1; drv_tag = "reset";
        @(posedge clk); #1;
        reset = 1'b0;
        m_num = 0; m_ctrl = '0; m_done = 1'b0; m_code = '0; m_cycles = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(); idle();
        rd(32'h800, 32'd0, "reset num");
        rd(32'h80C, 32'd0, "reset ctrl");
        rd_status();
        rd(32'h810, 32'd0, "reset cycles");

        // {3,1,2,0} ascending: five inversions, so 1 + 15 + 8 + 5 + 1 = 30 cycles.
        load4(32'd3, 32'd1, 32'd2, 32'd0);
        set_num(4); set_ctrl(3'd0);
        run_sort(cyc);
        check("pin cycles 3120", 32'(cyc), 32'd30);
        check("pin sorted w0", m_mem[0], 32'd0);
        check("pin sorted w3", m_mem[3], 32'd3);
        check_buf(4);
        load4(32'd3, 32'd2, 32'd1, 32'd0);
        run_sort(cyc);
        check("pin cycles reverse", 32'(cyc), 32'd32);
        check_buf(4);

        // Already sorted with interrupt enabled.
        load4(32'd0, 32'd1, 32'd2, 32'd3);
        set_ctrl(3'd4);
        run_sort(cyc);
        check("pin cycles sorted", 32'(cyc), 32'd11);
        rd_status();

        // Signed and unsigned descending.
        load4(32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0);
        set_ctrl(3'd3);
        run_sort(cyc);
        check("pin sdesc w0", m_mem[0], 32'd5);
        check("pin sdesc w3", m_mem[3], 32'h8000_0000);
        check_buf(4);
        load4(32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0);
        set_ctrl(3'd1);
        run_sort(cyc);
        check("pin udesc w1", m_mem[1], 32'h8000_0000);
        check("pin udesc w2", m_mem[2], 32'd5);
        check_buf(4);

        // Illegal lengths and the single-element case.
        set_ctrl(3'd0);
        set_num(0);      run_sort(cyc); check_buf(4);
        set_num(MM + 1); run_sort(cyc); check_buf(4);
        rd(32'h800, 32'(MM + 1), "num readback");
        set_num(1);      run_sort(cyc);
        check("pin cycles one", 32'(cyc), 32'd2);

        // Decode: unmapped offset, foreign block, abort while idle.
        rd(32'h814, 32'd0, "unmapped rd");
        wr(32'h1000, 32'hDEAD_BEEF, "foreign wr");
        rd(32'h0, m_mem[0], "foreign no effect");
        wr(32'h804, 32'd2, "idle abort");
        rd_status();

        // Abort 10 cycles into a full-length sort; host locked out meanwhile.
        for (int i = 0; i < MM; i++) buf_wr(i, 32'(MM - 1 - i));
        set_num(MM);
        m_code = 2'd0;
        wr(32'h804, 32'd1, "start long");
        rd(32'h0, 32'd0, "busy buf rd");
        wr(32'h800, 32'd5, "busy num wr");
        rd(32'h800, 32'(MM), "num locked");
        wr(32'h80C, 32'd4, "busy ctrl wr");
        rd(32'h80C, 32'd0, "ctrl locked");
        wr(32'h804, 32'd1, "busy restart");
        idle(); idle(); idle();
        wr(32'h804, 32'd2, "abort");
        m_code = 2'd2;
        rd_status();
        rd(32'h810, 32'd10, "abort cycles");

        // Reset in the middle of a sort.
        set_ctrl(3'd4);
        load4(32'd3, 32'd2, 32'd1, 32'd0);
        set_num(4);
        wr(32'h804, 32'd1, "start pre-reset");
        idle(); idle(); idle();
        do_reset();
        idle();
        rd_status();
        rd(32'h800, 32'd0, "post-reset num");
        rd(32'h80C, 32'd0, "post-reset ctrl");
        rd(32'h810, 32'd0, "post-reset cycles");
        buf_wr(0, 32'd2); buf_wr(1, 32'd1);
        set_num(2);
        run_sort(cyc);
        check("pin cycles pair", 32'(cyc), 32'd7);
        check_buf(2);

        // Randomized lengths, directions, signedness and value ranges.
        for (int it = 0; it < 24; it++) begin
            int n, nw, mode;
            logic [2:0] c;
            n = $urandom_range(2, 12);
            if (it % 8 == 7) n = (it % 16 == 7) ? 0 : MM + 1;
            nw = (n == 0 || n > MM) ? 4 : n;
            c = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 2);
            for (int i = 0; i < nw; i++) begin
                if (mode == 0)      buf_wr(i, 32'($urandom_range(0, 3)));
                else if (mode == 1) buf_wr(i, $urandom);
                else                buf_wr(i, 32'($urandom_range(0, 4)) - 32'd2);
            end
            set_num(n); set_ctrl(c);
            run_sort(cyc);
            check_buf(nw);
        end

        idle(); idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
